anti_theft_fsm: RTL and testbench



---
 rtl/anti_theft_fsm_if.sv | 28 ++
 rtl/anti_theft_fsm.sv | 140 ++++++++++++++
 tb/tb_anti_theft_fsm.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/anti_theft_fsm_if.sv
// Signal bundle between the anti-theft FSM and its sensors, timer and indicators.
// Ports: ignition/driver/passenger/reprogram/expired toward the FSM;
//        status/siren/startTimer/interval/state/nextState from the FSM.
interface anti_theft_fsm_if;
    logic       ignition;
    logic       driver;
    logic       passenger;
    logic       reprogram;
    logic       expired;
    logic       status;
    logic       siren;
    logic       startTimer;
    logic [1:0] interval;
    logic [2:0] state;
    logic [2:0] nextState;

    // Sensor / timer side: drives the inputs and observes the FSM outputs.
    modport master (
        output ignition, driver, passenger, reprogram, expired,
        input  status, siren, startTimer, interval, state, nextState
    );

    // FSM side.
    modport slave (
        input  ignition, driver, passenger, reprogram, expired,
        output status, siren, startTimer, interval, state, nextState
    );
endinterface

// File: rtl/anti_theft_fsm.sv
// Vehicle anti-theft control FSM: arms after doors close, counts down on a
// door opening, sounds the siren on timeout, and selects the external timer delay.
// Ports: clock, resetN (async active-low), bus (anti_theft_fsm_if.slave).
// Latency: state registers 1 cycle after input; nextState/startTimer/interval combinational.
// Optional ANTI_THEFT_BLINK_EN: status blinks with BLINK_HALF-cycle half-period in ARMED,
// otherwise status is held at 1 in ARMED.
module anti_theft_fsm #(
    parameter int unsigned BLINK_HALF = 4
) (
    input  logic                 clock,
    input  logic                 resetN,
    anti_theft_fsm_if.slave      bus
);

    if (BLINK_HALF < 1) begin : g_bad_blink_half
        $error("BLINK_HALF must be at least 1");
    end

    typedef enum logic [2:0] {
        ARMED      = 3'd0,
        TRIG_DRV   = 3'd1,
        TRIG_PASS  = 3'd2,
        ALARM      = 3'd3,
        ALARM_HOLD = 3'd4,
        DISARMED   = 3'd5,
        DOOR_OPEN  = 3'd6,
        ARMING     = 3'd7
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   any_door;
    logic   timed_next;
    logic   start_timer;
    logic   blink;

    assign any_door = bus.driver | bus.passenger;

    // State register
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q <= ARMED;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; priority is reprogram > ignition > door > expired.
    always_comb begin
        state_d = state_q;
        if (bus.reprogram) begin
            state_d = ARMING;
        end else begin
            unique case (state_q)
                ARMED: begin
                    if (bus.ignition)       state_d = DISARMED;
                    else if (bus.driver)    state_d = TRIG_DRV;
                    else if (bus.passenger) state_d = TRIG_PASS;
                end
                TRIG_DRV, TRIG_PASS: begin
                    if (bus.ignition)       state_d = DISARMED;
                    else if (bus.expired)   state_d = ALARM;
                end
                ALARM: begin
                    if (bus.ignition)       state_d = DISARMED;
                    else if (!any_door)     state_d = ALARM_HOLD;
                end
                ALARM_HOLD: begin
                    if (bus.ignition)       state_d = DISARMED;
                    else if (any_door)      state_d = ALARM;
                    else if (bus.expired)   state_d = ARMED;
                end
                DISARMED: begin
                    if (!bus.ignition && bus.driver) state_d = DOOR_OPEN;
                end
                DOOR_OPEN: begin
                    if (bus.ignition)       state_d = DISARMED;
                    else if (!any_door)     state_d = ARMING;
                end
                ARMING: begin
                    if (bus.ignition)       state_d = DISARMED;
                    else if (any_door)      state_d = DOOR_OPEN;
                    else if (bus.expired)   state_d = ARMED;
                end
                default: state_d = ARMED;
            endcase
        end
    end

    // The timer restarts whenever a timed state is entered, or re-entered by
    // reprogram. Expired-driven exits never land in a timed state, so expired
    // is never acted on in a cycle that restarts the timer.
    assign timed_next  = (state_d == TRIG_DRV) || (state_d == TRIG_PASS) ||
                         (state_d == ALARM_HOLD) || (state_d == ARMING);
    assign start_timer = timed_next && ((state_d != state_q) || bus.reprogram);

`ifdef ANTI_THEFT_BLINK_EN
    localparam int unsigned CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    logic [CW-1:0] blink_cnt;

    // Held cleared outside ARMED so every entry starts a fresh "on" half-period.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            blink_cnt <= '0;
            blink     <= 1'b1;
        end else if (state_q != ARMED) begin
            blink_cnt <= '0;
            blink     <= 1'b1;
        end else if (blink_cnt == CW'(BLINK_HALF - 1)) begin
            blink_cnt <= '0;
            blink     <= ~blink;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end
`else
    assign blink = 1'b1;
`endif

    // Outputs
    always_comb begin
        state_t sel;
        sel = start_timer ? state_d : state_q;
        bus.interval = 2'b00;
        unique case (sel)
            TRIG_DRV:   bus.interval = 2'b01;
            TRIG_PASS:  bus.interval = 2'b10;
            ALARM_HOLD: bus.interval = 2'b11;
            default:    bus.interval = 2'b00;
        endcase
    end

    assign bus.status     = (state_q == TRIG_DRV) || (state_q == TRIG_PASS) ||
                            ((state_q == ARMED) && blink);
    assign bus.siren      = (state_q == ALARM) || (state_q == ALARM_HOLD);
    assign bus.startTimer = start_timer;
    assign bus.state      = state_q;
    assign bus.nextState  = state_d;

endmodule

// File: tb/tb_anti_theft_fsm.sv
// Directed bench for anti_theft_fsm: walks the arming, trigger, alarm and
// disarm paths with hand-computed expectations, then checks async reset.
// Blink expectations adapt to whether ANTI_THEFT_BLINK_EN is defined.
module tb_anti_theft_fsm;

    logic clock;
    logic resetN;
    int   n_checks;
    int   n_errors;

    anti_theft_fsm_if bus ();

    anti_theft_fsm #(.BLINK_HALF(4)) dut (
        .clock  (clock),
        .resetN (resetN),
        .bus    (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        resetN        = 1'b0;
        bus.ignition  = 1'b0;
        bus.driver    = 1'b0;
        bus.passenger = 1'b0;
        bus.reprogram = 1'b0;
        bus.expired   = 1'b0;

        // Reset state
        #3;
        check("rst_state",  bus.state, 0);
        check("rst_next",   bus.nextState, 0);
        check("rst_status", bus.status, 1);
        check("rst_siren",  bus.siren, 0);
        check("rst_start",  bus.startTimer, 0);
        check("rst_intv",   bus.interval, 0);
        #9;
        resetN = 1'b1;

        // Idle in ARMED: blink half-period of 4 edges
        for (int k = 1; k <= 8; k++) begin
            step();
`ifdef ANTI_THEFT_BLINK_EN
            check("blink", bus.status, ((k / 4) % 2 == 0) ? 1 : 0);
`else
            check("armed_status", bus.status, 1);
`endif
        end

        // Driver door -> countdown -> alarm -> hold -> rearm
        bus.driver = 1'b1; #1;
        check("drv_start", bus.startTimer, 1);
        check("drv_intv",  bus.interval, 1);
        check("drv_next",  bus.nextState, 1);
        step();
        check("drv_state",  bus.state, 1);
        check("drv_status", bus.status, 1);
        check("drv_nostart", bus.startTimer, 0);
        check("drv_intv_hold", bus.interval, 1);
        bus.expired = 1'b1; #1;
        check("exp_next", bus.nextState, 3);
        step();
        check("alarm_state",  bus.state, 3);
        check("alarm_siren",  bus.siren, 1);
        check("alarm_status", bus.status, 0);
        bus.expired = 1'b0;
        bus.driver  = 1'b0; #1;
        check("hold_start", bus.startTimer, 1);
        check("hold_intv",  bus.interval, 3);
        step();
        check("hold_state", bus.state, 4);
        check("hold_siren", bus.siren, 1);
        bus.expired = 1'b1;
        step();
        check("rearm_state",  bus.state, 0);
        check("rearm_siren",  bus.siren, 0);
        check("rearm_status", bus.status, 1);
        bus.expired = 1'b0;

        // Passenger door, then ignition before expiry
        bus.passenger = 1'b1; #1;
        check("pass_start", bus.startTimer, 1);
        check("pass_intv",  bus.interval, 2);
        step();
        check("pass_state", bus.state, 2);
        check("pass_status", bus.status, 1);
        bus.ignition = 1'b1; bus.expired = 1'b1; #1;
        check("ign_beats_exp", bus.nextState, 5);
        check("ign_nostart", bus.startTimer, 0);
        step();
        check("dis_state",  bus.state, 5);
        check("dis_status", bus.status, 0);
        check("dis_siren",  bus.siren, 0);
        bus.expired = 1'b0;
        bus.passenger = 1'b0;

        // DISARMED -> DOOR_OPEN -> ARMING -> ARMED
        bus.ignition = 1'b0; bus.driver = 1'b1; #1;
        check("door_next", bus.nextState, 6);
        step();
        check("door_state", bus.state, 6);
        bus.driver = 1'b0; #1;
        check("arming_start", bus.startTimer, 1);
        check("arming_intv",  bus.interval, 0);
        step();
        check("arming_state", bus.state, 7);
        bus.passenger = 1'b1; bus.expired = 1'b1; #1;
        check("door_beats_exp", bus.nextState, 6);
        bus.passenger = 1'b0; #1;
        check("arming_exp_next", bus.nextState, 0);
        check("arming_exp_nostart", bus.startTimer, 0);
        step();
        check("armed_again", bus.state, 0);
        bus.expired = 1'b0;

        // Alarm hold with door reopened, then reprogram
        bus.driver = 1'b1; step();
        bus.expired = 1'b1; step();
        bus.expired = 1'b0; bus.driver = 1'b0; step();
        check("hold2_state", bus.state, 4);
        bus.passenger = 1'b1; #1;
        check("reopen_next", bus.nextState, 3);
        step();
        check("reopen_state", bus.state, 3);
        check("reopen_siren", bus.siren, 1);
        bus.reprogram = 1'b1; #1;
        check("reprog_start", bus.startTimer, 1);
        check("reprog_intv",  bus.interval, 0);
        check("reprog_next",  bus.nextState, 7);
        step();
        check("reprog_state", bus.state, 7);
        #1;
        check("reprog_restart", bus.startTimer, 1);
        bus.reprogram = 1'b0; bus.passenger = 1'b0; bus.expired = 1'b1;
        step();
        check("armed_third", bus.state, 0);

        // Back into ALARM, then async reset with no clock edge
        bus.expired = 1'b0; bus.driver = 1'b1; step();
        bus.expired = 1'b1; step();
        check("alarm2_state", bus.state, 3);
        #2;
        resetN = 1'b0;
        #1;
        check("async_state", bus.state, 0);
        check("async_siren", bus.siren, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
